// File: rtl/iomem_gpio.sv
// GPIO peripheral for the picosoc iomem bus: output data with SET/CLR/TGL,
// per-bit direction, synchronised inputs and edge interrupts with W1C pending.
module iomem_gpio #(
    parameter int         WIDTH       = 8,
    parameter logic [7:0] BASE_ADDR   = 8'h03,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    typedef enum logic [3:0] {
        OFF_DATA_OUT = 4'h0,
        OFF_DIR      = 4'h1,
        OFF_DATA_IN  = 4'h2,
        OFF_SET      = 4'h3,
        OFF_CLR      = 4'h4,
        OFF_TGL      = 4'h5,
        OFF_RISE_EN  = 4'h6,
        OFF_FALL_EN  = 4'h7,
        OFF_PEND     = 4'h8
    } reg_off_e;

    logic                                 ready_q, ready_d;
    logic [31:0]                          rdata_q, rdata_d;
    logic [WIDTH-1:0]                     out_q, out_d;
    logic [WIDTH-1:0]                     dir_q, dir_d;
    logic [WIDTH-1:0]                     rise_en_q, rise_en_d;
    logic [WIDTH-1:0]                     fall_en_q, fall_en_d;
    logic [WIDTH-1:0]                     pend_q, pend_d;
    logic [WIDTH-1:0]                     prev_q, prev_d;
    logic                                 irq_q, irq_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]    sync_q, sync_d;

    logic                                 sel;
    logic                                 wr;
    reg_off_e                             off;
    logic [31:0]                          bmask;
    logic [31:0]                          wmask;
    logic [WIDTH-1:0]                     bm;
    logic [WIDTH-1:0]                     wd;
    logic [WIDTH-1:0]                     in_s;
    logic [WIDTH-1:0]                     rise;
    logic [WIDTH-1:0]                     fall;
    logic [31:0]                          rd;
    logic                                 unused_bits;

    assign sel   = iomem_valid & ~ready_q & (iomem_addr[31:24] == BASE_ADDR);
    assign wr    = sel & (|iomem_wstrb);
    assign off   = reg_off_e'(iomem_addr[5:2]);
    assign bmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign wmask = iomem_wdata & bmask;
    assign bm    = bmask[WIDTH-1:0];
    assign wd    = wmask[WIDTH-1:0];
    assign in_s  = sync_q[SYNC_STAGES-1];
    assign rise  = in_s & ~prev_q & rise_en_q;
    assign fall  = ~in_s & prev_q & fall_en_q;

    // Address bits outside the decoded window, and data bits above WIDTH.
    assign unused_bits = ^{iomem_addr[23:6], iomem_addr[1:0], wmask, bmask};

    // Read mux always reflects register state before any write in this access.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        rd = 32'h0;
        case (off)
            OFF_DATA_OUT: rd[WIDTH-1:0] = out_q;
            OFF_DIR:      rd[WIDTH-1:0] = dir_q;
            OFF_DATA_IN:  rd[WIDTH-1:0] = in_s;
            OFF_RISE_EN:  rd[WIDTH-1:0] = rise_en_q;
            OFF_FALL_EN:  rd[WIDTH-1:0] = fall_en_q;
            OFF_PEND:     rd[WIDTH-1:0] = pend_q;
            default:      rd = 32'h0;
        endcase
    end

    always_comb begin
        logic [WIDTH-1:0] w1c;
        ready_d   = sel;
        rdata_d   = sel ? rd : 32'h0;
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;

        if (wr) begin
            case (off)
                OFF_DATA_OUT: out_d     = (out_q & ~bm) | (iomem_wdata[WIDTH-1:0] & bm);
                OFF_DIR:      dir_d     = (dir_q & ~bm) | (iomem_wdata[WIDTH-1:0] & bm);
                OFF_SET:      out_d     = out_q | wd;
                OFF_CLR:      out_d     = out_q & ~wd;
                OFF_TGL:      out_d     = out_q ^ wd;
                OFF_RISE_EN:  rise_en_d = (rise_en_q & ~bm) | (iomem_wdata[WIDTH-1:0] & bm);
                OFF_FALL_EN:  fall_en_d = (fall_en_q & ~bm) | (iomem_wdata[WIDTH-1:0] & bm);
                OFF_PEND:     w1c       = wd;
                default:      ;
            endcase
        end

        // A new event in the same cycle as its W1C keeps the bit set.
        pend_d = (pend_q & ~w1c) | rise | fall;
        irq_d  = |pend_q;
        prev_d = in_s;

        sync_d[0] = gpio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q   <= 1'b0;
            rdata_q   <= 32'h0;
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            irq_q     <= 1'b0;
            sync_q    <= '0;
        end else begin
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            prev_q    <= prev_d;
            irq_q     <= irq_d;
            sync_q    <= sync_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign gpio_out    = out_q;
    assign gpio_oe     = dir_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gpio.sv
// Directed bench for iomem_gpio (WIDTH=8): register access, atomic writes,
// edge interrupts, W1C races, address filtering and asynchronous reset.
module tb_iomem_gpio;

    localparam int W = 8;

    logic         clk;
    logic         resetn;
    logic         iomem_valid;
    logic         iomem_ready;
    logic [3:0]   iomem_wstrb;
    logic [31:0]  iomem_addr;
    logic [31:0]  iomem_wdata;
    logic [31:0]  iomem_rdata;
    logic [W-1:0] gpio_in;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_oe;
    logic         irq;

    int n_cmp = 0;
    int n_bad = 0;

    iomem_gpio #(.WIDTH(W), .BASE_ADDR(8'h03), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .gpio_in     (gpio_in),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access; lat = negedges until ready was seen, -1 if it never came.
    task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdat, output logic [31:0] rd, output int lat);
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdat;
        lat = -1;
        rd  = 32'hDEAD_BEEF;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (iomem_ready) begin
                lat = i;
                rd  = iomem_rdata;
                break;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
    endtask

    task automatic do_reset();
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        resetn      = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        logic [31:0] addrs [3] = '{32'h0300_0000, 32'h0300_0004, 32'h0300_0020};
        n_cmp++;
        if ({gpio_out, gpio_oe, irq, iomem_ready} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got out=%h oe=%h irq=%b rdy=%b, want all 0",
                     gpio_out, gpio_oe, irq, iomem_ready);
        end
        foreach (addrs[i]) begin
            bus(addrs[i], 4'h0, 32'h0, rd, lat);
            n_cmp++;
            if (lat !== 1 || rd !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_read %h: got lat=%0d rdata=%h, want lat=1 rdata=0",
                         addrs[i], lat, rd);
            end
        end
    endtask

    task automatic test_data_out();
        logic [31:0] rd;
        int lat;
        logic [31:0] a   [4] = '{32'h0300_0000, 32'h0300_000C, 32'h0300_0010, 32'h0300_0014};
        logic [31:0] d   [4] = '{32'hA5, 32'h0A, 32'h01, 32'hFF};
        logic [W-1:0] ex [4] = '{8'hA5, 8'hAF, 8'hAE, 8'h51};
        foreach (a[i]) begin
            bus(a[i], 4'hF, d[i], rd, lat);
            n_cmp++;
            if (gpio_out !== ex[i]) begin
                n_bad++;
                $display("FAIL data_out step%0d: got %h, want %h", i, gpio_out, ex[i]);
            end
        end
        bus(32'h0300_0000, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h51) begin
            n_bad++;
            $display("FAIL read_data_out: got %h, want 00000051", rd);
        end
        bus(32'h0300_000C, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h0 || lat !== 1) begin
            n_bad++;
            $display("FAIL read_set: got %h lat=%0d, want 0 lat=1", rd, lat);
        end
        // Partial strobe on SET only touches lane 1, which is above WIDTH.
        bus(32'h0300_000C, 4'b0010, 32'h0000_FFFF, rd, lat);
        n_cmp++;
        if (gpio_out !== 8'h51) begin
            n_bad++;
            $display("FAIL set_strobe: got %h, want 51", gpio_out);
        end
    endtask

    task automatic test_dir();
        logic [31:0] rd;
        int lat;
        bus(32'h0300_0004, 4'b0001, 32'h1234_FF0F, rd, lat);
        n_cmp++;
        if (gpio_oe !== 8'h0F) begin
            n_bad++;
            $display("FAIL dir_write: got %h, want 0F", gpio_oe);
        end
        bus(32'h0300_0004, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h0000_000F) begin
            n_bad++;
            $display("FAIL dir_read: got %h, want 0000000F", rd);
        end
        // Lane 1 strobe alone must leave the low byte untouched.
        bus(32'h0300_0004, 4'b0010, 32'h0000_AAFF, rd, lat);
        n_cmp++;
        if (gpio_oe !== 8'h0F || rd !== 32'h0000_000F) begin
            n_bad++;
            $display("FAIL dir_lane1: got oe=%h rd=%h, want oe=0F rd=0000000F", gpio_oe, rd);
        end
    endtask

    task automatic test_edges();
        logic [31:0] rd;
        int lat;
        gpio_in = 8'h02;
        repeat (4) @(negedge clk);
        bus(32'h0300_0008, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h02) begin
            n_bad++;
            $display("FAIL data_in: got %h, want 00000002", rd);
        end
        bus(32'h0300_0018, 4'hF, 32'h01, rd, lat);
        bus(32'h0300_001C, 4'hF, 32'h02, rd, lat);
        bus(32'h0300_0020, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_bad++;
            $display("FAIL pend_no_retro: got %h, want 0", rd);
        end
        @(negedge clk);
        gpio_in = 8'h03;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL irq_early at k+2: got %b, want 0", irq);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_late at k+3: got %b, want 1", irq);
        end
        bus(32'h0300_0020, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h01) begin
            n_bad++;
            $display("FAIL pend_rise: got %h, want 00000001", rd);
        end
        gpio_in = 8'h01;
        repeat (4) @(negedge clk);
        bus(32'h0300_0020, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h03) begin
            n_bad++;
            $display("FAIL pend_fall: got %h, want 00000003", rd);
        end
        bus(32'h0300_0020, 4'hF, 32'h01, rd, lat);
        bus(32'h0300_0020, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h02) begin
            n_bad++;
            $display("FAIL w1c_bit0: got %h, want 00000002", rd);
        end
        bus(32'h0300_0020, 4'hF, 32'h02, rd, lat);
        bus(32'h0300_0020, 4'h0, 32'h0, rd, lat);
        @(negedge clk);
        n_cmp++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL w1c_bit1: got pend=%h irq=%b, want 0 0", rd, irq);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd;
        int lat;
        gpio_in = 8'h00;
        repeat (4) @(negedge clk);
        // bit1 fell again above; clear whatever is pending before the race.
        bus(32'h0300_0020, 4'hF, 32'hFF, rd, lat);
        gpio_in = 8'h01;
        // Edge k, then k+1; the bus task's sel edge is k+2, where rise is live.
        @(posedge clk);
        @(posedge clk);
        bus(32'h0300_0020, 4'hF, 32'h01, rd, lat);
        bus(32'h0300_0020, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h01) begin
            n_bad++;
            $display("FAIL w1c_race: got %h, want 00000001", rd);
        end
    endtask

    task automatic test_address();
        logic [31:0] rd;
        int lat;
        bus(32'h0200_0000, 4'hF, 32'hFF, rd, lat);
        n_cmp++;
        if (lat !== -1 || gpio_out !== 8'h51) begin
            n_bad++;
            $display("FAIL wrong_base: got lat=%0d out=%h, want no ready out=51", lat, gpio_out);
        end
        bus(32'h0300_0024, 4'hF, 32'hFFFF_FFFF, rd, lat);
        n_cmp++;
        if (lat !== 1 || rd !== 32'h0 || gpio_out !== 8'h51 || gpio_oe !== 8'h0F) begin
            n_bad++;
            $display("FAIL off_24: got lat=%0d rd=%h out=%h oe=%h, want 1 0 51 0F",
                     lat, rd, gpio_out, gpio_oe);
        end
        // Ignored middle address bits still hit DATA_OUT.
        bus(32'h03AB_CD40, 4'h0, 32'h0, rd, lat);
        n_cmp++;
        if (rd !== 32'h51) begin
            n_bad++;
            $display("FAIL addr_alias: got %h, want 00000051", rd);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'h0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({iomem_ready, iomem_rdata, gpio_out, gpio_oe, irq} !== 50'h0) begin
            n_bad++;
            $display("FAIL reset_mid: got rdy=%b rd=%h out=%h oe=%h irq=%b, want all 0",
                     iomem_ready, iomem_rdata, gpio_out, gpio_oe, irq);
        end
        iomem_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        gpio_in = '0;
        do_reset();
        test_reset();
        test_data_out();
        test_dir();
        test_edges();
        test_w1c_race();
        test_address();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
